servo_frame_generator: RTL and testbench
========================================

// Module: servo_frame_generator
// PURPOSE
//   Drives the motor-controller (ESC) servo line. Owns the 20 ms servo frame, produces the
//   5-bit State (frame index 0..23) consumed by the pulse-modulation stage, and turns the
//   Pulse width it returns (in CLK ticks) into the physical PWM_Out waveform.
//   Sits directly downstream of pulse modulation and drives the FPGA output pin.
// PARAMETERS
//   FRAME_TICKS    2000000  CLK ticks per servo frame (20 ms at 100 MHz)
//   NUM_STATES     24       frames per modulation cycle; State counts 0..NUM_STATES-1
//   STATE_ADV_TICK 1000000  frame counter value at which State advances (mid-frame)
//   PULSE_MIN      100000   lower clamp on pulse width (1 ms)
//   PULSE_MAX      200000   upper clamp on pulse width (2 ms)
//   PULSE_NEUTRAL  150000   width used after reset and until the first sample (1.5 ms)
// PORTS
//   CLK         in   1   system clock, 100 MHz
//   RST         in   1   synchronous, active-high reset
//   Enable      in   1   1 = drive pulses; 0 = no pulse (line held low) from next frame
//   Pulse       in   21  requested high time in CLK ticks, from pulse modulation
//   State       out  5   current frame index, to pulse modulation
//   PWM_Out     out  1   servo signal to ESC
//   FrameStart  out  1   one-cycle strobe on the first cycle of every frame
//   Clamped     out  1   one-cycle strobe when the sampled Pulse was outside [MIN,MAX]
// BEHAVIOUR
//   Reset (RST=1 at a CLK edge): cnt=0, State=0, width_q=PULSE_NEUTRAL, PWM_Out=0,
//     FrameStart=0, Clamped=0. Reset wins over every other event and may occur mid-frame;
//     the frame restarts from cnt=0 on the first cycle after RST deasserts.
//   Frame counter cnt (21 bit): increments every cycle; at FRAME_TICKS-1 wraps to 0.
//   State: when cnt==STATE_ADV_TICK, State <= (State==NUM_STATES-1) ? 0 : State+1.
//     Advancing mid-frame gives upstream (1-cycle registered) ample settle time before the
//     next sample; State never changes at a frame boundary.
//   Width sample: on the cycle cnt==FRAME_TICKS-1, width_q is loaded for the next frame:
//     Enable==0              -> width_q <= 0, Clamped <= 0
//     Pulse <  PULSE_MIN     -> width_q <= PULSE_MIN, Clamped <= 1
//     Pulse >  PULSE_MAX     -> width_q <= PULSE_MAX, Clamped <= 1
//     otherwise              -> width_q <= Pulse[20:0], Clamped <= 0
//     Clamped is a strobe: 0 on all other cycles. Pulse changes at any other time are
//     ignored; width is constant for a whole frame (no glitching mid-pulse).
//   PWM_Out: registered, PWM_Out <= (cnt < width_q). One cycle latency from cnt, so the
//     line rises on the cycle after cnt==0 and is high for exactly width_q cycles/frame.
//     width_q==0 -> line stays low the whole frame.
//   FrameStart: registered, FrameStart <= (cnt == 0); coincides with PWM_Out rising edge.
//   Comparisons unsigned; Pulse is 21 bits, no truncation before clamping.
//   Enable only takes effect at the next frame sample; a pulse in progress completes.
// TESTING
//   Reset: hold RST 5 cycles -> State=0, PWM_Out=0, FrameStart=0; first frame high for
//     150000 cycles, FrameStart every 2000000 cycles thereafter.
//   Pulse=100000 steady, Enable=1 -> from frame 2 on, PWM_Out high exactly 100000 cycles,
//     low 1900000; Clamped never asserted.
//   Pulse=250000 then Pulse=50000 -> widths 200000 and 100000 respectively, Clamped strobes
//     once per frame on the sample cycle.
//   Run 25 frames -> State sequence 0,1,..,23,0,1 changing only at cnt==1000000.
//   Change Pulse 180000->120000 at cnt=50000 mid-frame -> current frame stays 180000,
//     next frame 120000; Enable=0 mid-frame -> current pulse completes, next frame no pulse,
//     State still advances.
//   Assert RST at cnt=70000 while PWM_Out=1 -> PWM_Out=0 next cycle, State=0, new frame
//     starts with 150000-cycle neutral pulse.

Source files
------------

// File: rtl/servo_frame_generator.sv
// Servo frame generator: owns the servo frame timing, advances the modulation
// State mid-frame, and turns the sampled pulse width into the PWM_Out waveform.
module servo_frame_generator #(
    parameter int unsigned FRAME_TICKS    = 2000000,
    parameter int unsigned NUM_STATES     = 24,
    parameter int unsigned STATE_ADV_TICK = 1000000,
    parameter int unsigned PULSE_MIN      = 100000,
    parameter int unsigned PULSE_MAX      = 200000,
    parameter int unsigned PULSE_NEUTRAL  = 150000,
    localparam int unsigned CNT_W         = 21,
    localparam int unsigned ST_W          = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Enable,
    input  logic [CNT_W-1:0] Pulse,
    output logic [ST_W-1:0]  State,
    output logic             PWM_Out,
    output logic             FrameStart,
    output logic             Clamped
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [ST_W-1:0]  state_q, state_d;
    logic             pwm_q, pwm_d;
    logic             fs_q, fs_d;
    logic             clamped_q, clamped_d;
    logic             frame_end_c;
    logic             state_adv_c;

    assign frame_end_c = (cnt_q == CNT_W'(FRAME_TICKS - 1));
    assign state_adv_c = (cnt_q == CNT_W'(STATE_ADV_TICK));

    // Next-state logic; the width is only reloaded on the last tick of a frame
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        width_d   = width_q;
        state_d   = state_q;
        clamped_d = 1'b0;
        pwm_d     = (cnt_q < width_q);
        fs_d      = (cnt_q == '0);

        if (frame_end_c) begin
            cnt_d = '0;
            if (!Enable) begin
                width_d = '0;
            end else if (Pulse < CNT_W'(PULSE_MIN)) begin
                width_d   = CNT_W'(PULSE_MIN);
                clamped_d = 1'b1;
            end else if (Pulse > CNT_W'(PULSE_MAX)) begin
                width_d   = CNT_W'(PULSE_MAX);
                clamped_d = 1'b1;
            end else begin
                width_d = Pulse;
            end
        end

        if (state_adv_c) begin
            state_d = (state_q == ST_W'(NUM_STATES - 1)) ? '0 : state_q + ST_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            width_q   <= CNT_W'(PULSE_NEUTRAL);
            state_q   <= '0;
            pwm_q     <= 1'b0;
            fs_q      <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            state_q   <= state_d;
            pwm_q     <= pwm_d;
            fs_q      <= fs_d;
            clamped_q <= clamped_d;
        end
    end

    assign State      = state_q;
    assign PWM_Out    = pwm_q;
    assign FrameStart = fs_q;
    assign Clamped    = clamped_q;

endmodule

// File: tb/tb_servo_frame_generator.sv
// Self-checking bench for servo_frame_generator with a scaled-down frame so many
// frames fit in a short run; reference model works from frame/phase arithmetic.
module tb_servo_frame_generator;

    localparam int unsigned F    = 200;
    localparam int unsigned NS   = 24;
    localparam int unsigned ADV  = 100;
    localparam int unsigned PMIN = 40;
    localparam int unsigned PMAX = 80;
    localparam int unsigned PNEU = 60;
    localparam int unsigned NFR  = 256;

    logic        clk;
    logic        rst;
    logic        en;
    logic [20:0] pulse;
    logic [4:0]  State;
    logic        PWM_Out;
    logic        FrameStart;
    logic        Clamped;

    // k = clock edges since the last reset edge; w/cl = width and clamp per frame index
    int unsigned k;
    int unsigned w [NFR];
    bit          cl[NFR];
    int          vectors;
    int          miscompares;

    servo_frame_generator #(
        .FRAME_TICKS   (F),
        .NUM_STATES    (NS),
        .STATE_ADV_TICK(ADV),
        .PULSE_MIN     (PMIN),
        .PULSE_MAX     (PMAX),
        .PULSE_NEUTRAL (PNEU)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .Enable    (en),
        .Pulse     (pulse),
        .State     (State),
        .PWM_Out   (PWM_Out),
        .FrameStart(FrameStart),
        .Clamped   (Clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and update the model with the inputs present at that edge
    task automatic tick();
        int unsigned n;
        @(posedge clk);
        if (rst) begin
            k = 0;
            for (int i = 0; i < int'(NFR); i++) begin
                w[i]  = 0;
                cl[i] = 1'b0;
            end
            w[0] = PNEU;
        end else begin
            k++;
            if ((k - 1) % F == F - 1) begin
                n = (k - 1) / F + 1;
                if (n < NFR) begin
                    if (!en) begin
                        w[n] = 0;  cl[n] = 1'b0;
                    end else if (32'(pulse) < PMIN) begin
                        w[n] = PMIN; cl[n] = 1'b1;
                    end else if (32'(pulse) > PMAX) begin
                        w[n] = PMAX; cl[n] = 1'b1;
                    end else begin
                        w[n] = 32'(pulse); cl[n] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    // Expected {State, PWM_Out, FrameStart, Clamped} after the current edge
    function automatic logic [7:0] expv();
        int unsigned p, n, st;
        logic        c;
        if (k == 0) return 8'h00;
        p  = (k - 1) % F;
        n  = (k - 1) / F;
        st = (k - 1 < ADV) ? 0 : (((k - 1 - ADV) / F) + 1) % NS;
        c  = (p == F - 1) && (n + 1 < NFR) && cl[n + 1];
        return {5'(st), (p < w[n]), (p == 0), c};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; pulse = 21'(PNEU);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=00", i, {State, PWM_Out, FrameStart, Clamped});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                miscompares++;
                $display("FAIL reset_run k=%0d got=%h exp=%h", k, {State, PWM_Out, FrameStart, Clamped}, expv());
            end
            pulse = 21'($urandom_range(PMIN, PMAX));
        end
    endtask

    task automatic test_min_steady();
        int unsigned hi;
        pulse = 21'(PMIN); en = 1'b1;
        for (int i = 0; i < int'(3 * F); i++) begin
            tick();
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                miscompares++;
                $display("FAIL min_steady k=%0d got=%h exp=%h", k, {State, PWM_Out, FrameStart, Clamped}, expv());
            end
        end
        for (int i = 0; i < int'(F) && (k % F) != 0; i++) tick();
        hi = 0;
        for (int i = 0; i < int'(F); i++) begin
            tick();
            hi += 32'(PWM_Out);
        end
        vectors++;
        if (hi != PMIN) begin
            miscompares++;
            $display("FAIL min_width got=%0d exp=%0d", hi, PMIN);
        end
    endtask

    task automatic test_clamp();
        logic [20:0] vals[10];
        vals = '{21'd100, 21'd20, 21'd39, 21'd40, 21'd80, 21'd81,
                 21'h1FFFFF, 21'd0, 21'h100050, 21'd60};
        en = 1'b1;
        foreach (vals[j]) begin
            pulse = vals[j];
            for (int i = 0; i < int'(F); i++) begin
                tick();
                vectors++;
                if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                    miscompares++;
                    $display("FAIL clamp p=%0d k=%0d got=%h exp=%h", vals[j], k, {State, PWM_Out, FrameStart, Clamped}, expv());
                end
            end
        end
    endtask

    task automatic test_state_wrap();
        en = 1'b1;
        for (int i = 0; i < int'(26 * F); i++) begin
            tick();
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                miscompares++;
                $display("FAIL state_wrap k=%0d got=%h exp=%h", k, {State, PWM_Out, FrameStart, Clamped}, expv());
            end
            if ($urandom_range(0, 29) == 0) pulse = 21'($urandom_range(0, 120));
            if ($urandom_range(0, 149) == 0) pulse = 21'($urandom);
            if ($urandom_range(0, 99) == 0) en = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
    endtask

    task automatic test_mid_change();
        en = 1'b1; pulse = 21'd72;
        for (int i = 0; i < int'(3 * F); i++) begin
            tick();
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                miscompares++;
                $display("FAIL mid_change k=%0d got=%h exp=%h", k, {State, PWM_Out, FrameStart, Clamped}, expv());
            end
            if (i == int'(F)) begin
                for (int j = 0; j < int'(F) && (k % F) != 20; j++) tick();
                pulse = 21'd48;
            end
            if (i == int'(2 * F)) begin
                for (int j = 0; j < int'(F) && (k % F) != 30; j++) tick();
                en = 1'b0;
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int unsigned hi;
        en = 1'b1; pulse = 21'd72;
        for (int i = 0; i < int'(F); i++) tick();
        for (int i = 0; i < int'(F) && (k % F) != 28; i++) tick();
        vectors++;
        if (PWM_Out !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_pwm got=%b exp=1", PWM_Out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({State, PWM_Out, FrameStart, Clamped} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid got=%h exp=00", {State, PWM_Out, FrameStart, Clamped});
        end
        hi = 0;
        for (int i = 0; i < int'(2 * F); i++) begin
            tick();
            if (i < int'(F)) hi += 32'(PWM_Out);
            vectors++;
            if ({State, PWM_Out, FrameStart, Clamped} !== expv()) begin
                miscompares++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", k, {State, PWM_Out, FrameStart, Clamped}, expv());
            end
        end
        vectors++;
        if (hi != PNEU) begin
            miscompares++;
            $display("FAIL neutral_width got=%0d exp=%0d", hi, PNEU);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; k = 0;
        rst = 1'b1; en = 1'b0; pulse = '0;
        test_reset();
        test_min_steady();
        test_clamp();
        test_state_wrap();
        test_mid_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
